param_divider: RTL and testbench

PARAM_DIVIDER -- requirements
Module: param_divider

---
 rtl/param_divider.sv | 158 +++++++++++++++
 tb/tb_param_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/param_divider.sv
// Sequential restoring divider: one quotient bit per cycle, signed or unsigned operands,
// with divide-by-zero and quotient-overflow detection against a narrower QW-bit result.
module param_divider #(
    parameter int DW = 10,
    parameter int VW = 5,
    parameter int QW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          finish,
    input  logic          sgn,
    input  logic [DW-1:0] AIN,
    input  logic [VW-1:0] DIN,
    output logic [QW-1:0] QUO,
    output logic [VW-1:0] REM,
    output logic          busy,
    output logic          done,
    output logic          divby0,
    output logic          overflow
);
    typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

    localparam int CW = $clog2(DW + 1);
    localparam logic [DW:0] ULIM = (DW+1)'(1) << QW;
    localparam logic [DW:0] SLIM = (DW+1)'(1) << (QW - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [DW-1:0] a_cap;
    logic [VW-1:0] d_cap;
    logic          sgn_cap;
    logic [DW-1:0] q_work;
    logic [VW-1:0] r_work;
    logic [VW-1:0] d_mag;
    logic          neg_q, neg_r;

    logic [DW-1:0] a_mag_c;
    logic [VW-1:0] d_mag_c;
    logic [VW:0]   trial_sh;
    logic [VW-1:0] trial_diff;
    logic          trial_ge;
    logic [VW-1:0] r_step;
    logic [DW-1:0] q_step;
    logic          ovf_fin;

    function automatic logic ovf_check(input logic [DW-1:0] qm, input logic s, input logic nq);
        logic [DW:0] qx;
        qx = {1'b0, qm};
        if (!s)      return (qx >= ULIM);
        else if (nq) return (qx > SLIM);
        else         return (qx >= SLIM);
    endfunction

    function automatic logic [QW-1:0] quo_fix(input logic [DW-1:0] qm, input logic nq);
        logic signed [DW-1:0] qs;
        qs = nq ? -$signed(qm) : $signed(qm);
        return qs[QW-1:0];
    endfunction

    function automatic logic [VW-1:0] rem_fix(input logic [VW-1:0] rm, input logic nr);
        logic signed [VW-1:0] rs;
        rs = nr ? -$signed(rm) : $signed(rm);
        return rs;
    endfunction

    always_comb begin
        a_mag_c    = (sgn_cap && a_cap[DW-1]) ? -a_cap : a_cap;
        d_mag_c    = (sgn_cap && d_cap[VW-1]) ? -d_cap : d_cap;
        // The difference is only kept when it is below d_mag, so VW bits suffice.
        trial_sh   = {r_work, q_work[DW-1]};
        trial_ge   = (trial_sh >= {1'b0, d_mag});
        trial_diff = trial_sh[VW-1:0] - d_mag;
        r_step     = trial_ge ? trial_diff : trial_sh[VW-1:0];
        q_step     = {q_work[DW-2:0], trial_ge};
        ovf_fin    = ovf_check(q_step, sgn_cap, neg_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CHECK;
            CHECK:   state_nxt = (d_cap == '0) ? DONE : RUN;
            RUN:     if (cnt <= CW'(1)) state_nxt = DONE;
            DONE:    if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CHECK) || (state == RUN);
        done = (state == DONE);
    end

    // Operand capture and working registers carry no reset.
    always_ff @(posedge clk) begin
        unique case (state)
            IDLE: if (start) begin
                a_cap   <= AIN;
                d_cap   <= DIN;
                sgn_cap <= sgn;
            end
            CHECK: begin
                q_work <= a_mag_c;
                r_work <= '0;
                d_mag  <= d_mag_c;
                neg_q  <= sgn_cap & (a_cap[DW-1] ^ d_cap[VW-1]);
                neg_r  <= sgn_cap & a_cap[DW-1];
            end
            RUN: begin
                q_work <= q_step;
                r_work <= r_step;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            QUO      <= '0;
            REM      <= '0;
            divby0   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                CHECK: begin
                    if (d_cap == '0) begin
                        divby0   <= 1'b1;
                        overflow <= 1'b0;
                        QUO      <= '0;
                        REM      <= '0;
                    end else begin
                        cnt <= CW'(DW);
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CW'(1)) begin
                        overflow <= ovf_fin;
                        QUO      <= ovf_fin ? '0 : quo_fix(q_step, neg_q);
                        REM      <= ovf_fin ? '0 : rem_fix(r_step, neg_r);
                    end
                end
                DONE: if (finish) begin
                    divby0   <= 1'b0;
                    overflow <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_param_divider.sv
// Randomized self-checking bench for param_divider against an integer-arithmetic model.
module tb_param_divider;
    localparam int DW = 10;
    localparam int VW = 5;
    localparam int QW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          finish = 1'b0;
    logic          sgn = 1'b0;
    logic [DW-1:0] AIN = '0;
    logic [VW-1:0] DIN = '0;
    logic [QW-1:0] QUO;
    logic [VW-1:0] REM;
    logic          busy, done, divby0, overflow;

    param_divider #(.DW(DW), .VW(VW), .QW(QW)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish), .sgn(sgn),
        .AIN(AIN), .DIN(DIN), .QUO(QUO), .REM(REM), .busy(busy), .done(done),
        .divby0(divby0), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int cap_cyc = 0;
    bit active  = 0;
    bit in_rst  = 1;

    // expected results of the transaction in flight
    logic [QW-1:0] e_quo;
    logic [VW-1:0] e_rem;
    bit            e_div0, e_ovf;
    int            e_lat;

    // DUT values seen on the last done cycle
    int last_quo, last_rem, last_div0, last_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model(input bit s, input logic [DW-1:0] a, input logic [VW-1:0] d);
        int av, dv, q, r;
        bit ov;
        av = s ? int'($signed(a)) : int'(a);
        dv = s ? int'($signed(d)) : int'(d);
        if (dv == 0) begin
            e_div0 = 1; e_ovf = 0; e_quo = '0; e_rem = '0; e_lat = 1;
        end else begin
            q  = av / dv;
            r  = av % dv;
            ov = s ? (q < -(1 << (QW-1)) || q > (1 << (QW-1)) - 1) : (q >= (1 << QW));
            e_div0 = 0;
            e_ovf  = ov;
            e_quo  = ov ? '0 : q[QW-1:0];
            e_rem  = ov ? '0 : r[VW-1:0];
            e_lat  = DW + 1;
        end
    endtask

    always @(negedge clk) begin
        int el;
        bit exp_done;
        if (!in_rst) begin
            if (active) begin
                el       = cyc - cap_cyc;
                exp_done = (el >= e_lat);
                chk("busy", int'(busy), int'(!exp_done));
                chk("done", int'(done), int'(exp_done));
                if (done) begin
                    chk("quo", int'(QUO), int'(e_quo));
                    chk("rem", int'(REM), int'(e_rem));
                    chk("divby0", int'(divby0), int'(e_div0));
                    chk("overflow", int'(overflow), int'(e_ovf));
                    last_quo = int'(QUO); last_rem = int'(REM);
                    last_div0 = int'(divby0); last_ovf = int'(overflow);
                end
            end else begin
                chk("idle_busy", int'(busy), 0);
                chk("idle_done", int'(done), 0);
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the finish edge.
    task automatic do_div(input bit s, input logic [DW-1:0] a, input logic [VW-1:0] d,
                          input bit keep_start);
        int guard;
        sgn = s; AIN = a; DIN = d; start = 1'b1;
        model(s, a, d);
        @(posedge clk); #1;
        cap_cyc = cyc; active = 1;
        guard = 0;
        while (!done && guard < 40) begin
            start  = keep_start ? 1'b1 : 1'($urandom_range(0, 1));
            AIN    = DW'($urandom);
            DIN    = VW'($urandom);
            sgn    = 1'($urandom_range(0, 1));
            finish = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            guard++;
        end
        finish = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
        repeat ($urandom_range(0, 2)) begin
            if (!keep_start) start = 1'($urandom_range(0, 1));
            AIN = DW'($urandom);
            @(posedge clk); #1;
        end
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        active = 0;
        start  = keep_start;
    endtask

    task automatic lit(input string nm, input int q, input int r, input int dz, input int ov);
        chk({nm, "_quo"}, last_quo, q);
        chk({nm, "_rem"}, last_rem, r);
        chk({nm, "_div0"}, last_div0, dz);
        chk({nm, "_ovf"}, last_ovf, ov);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_quo", int'(QUO), 0);
        chk("rst_rem", int'(REM), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_div0", int'(divby0), 0);
        chk("rst_ovf", int'(overflow), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; in_rst = 0;
        @(posedge clk); #1;

        do_div(0, 10'd100, 5'd7, 0);   lit("u100_7", 14, 2, 0, 0);
        do_div(0, 10'd1000, 5'd3, 0);  lit("u1000_3", 0, 0, 0, 1);
        do_div(0, 10'd5, 5'd0, 0);     lit("u5_0", 0, 0, 1, 0);
        do_div(1, 10'd924, 5'd7, 0);   lit("sm100_7", 50, 30, 0, 0);
        do_div(1, 10'd100, 5'd25, 0);  lit("s100_m7", 50, 2, 0, 0);
        do_div(1, 10'd992, 5'd1, 0);   lit("sm32_1", 32, 0, 0, 0);
        do_div(1, 10'd32, 5'd1, 0);    lit("s32_1", 0, 0, 0, 1);
        do_div(0, 10'd63, 5'd1, 0);    lit("u63_1", 63, 0, 0, 0);
        do_div(0, 10'd64, 5'd1, 0);    lit("u64_1", 0, 0, 0, 1);

        // start held through RUN and DONE, acknowledged with start still high
        do_div(0, 10'd200, 5'd9, 1);   lit("hold1", 22, 2, 0, 0);
        do_div(0, 10'd45, 5'd6, 0);    lit("hold2", 7, 3, 0, 0);

        // reset mid-RUN
        sgn = 0; AIN = 10'd300; DIN = 5'd7; start = 1'b1;
        model(0, 10'd300, 5'd7);
        @(posedge clk); #1;
        cap_cyc = cyc; active = 1; start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1; in_rst = 1; active = 0;
        #1;
        chk("mrst_quo", int'(QUO), 0);
        chk("mrst_rem", int'(REM), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_div0", int'(divby0), 0);
        chk("mrst_ovf", int'(overflow), 0);
        @(posedge clk); #1;
        chk("mrst_hold_busy", int'(busy), 0);
        rst = 1'b0; in_rst = 0;
        do_div(0, 10'd63, 5'd8, 0);    lit("u63_8", 7, 7, 0, 0);

        for (int i = 0; i < 150; i++) begin
            logic [DW-1:0] ra;
            logic [VW-1:0] rd;
            ra = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 80)) : DW'($urandom);
            rd = ($urandom_range(0, 9) == 0) ? '0 : VW'($urandom);
            do_div(1'($urandom_range(0, 1)), ra, rd, 1'($urandom_range(0, 7) == 0));
        end
        start = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
